// File: rtl/cv32e40x_elastic_pipe.sv
// -----------------------------------------------------------------------------
// cv32e40x_elastic_pipe
//
// DEPTH-stage elastic register chain with a valid/ready handshake at both ends.
// Empty stages (bubbles) collapse: a stage accepts a word whenever it is empty
// or the stage downstream of it can move, so a stall at the output only freezes
// the words that are packed against it.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset (clears valids, loads RESET_VALUE)
//   flush      synchronous discard of every stored word (data kept, valid cleared)
//   in_valid   producer offers in_data
//   in_ready   pipe accepts in_data this cycle
//   in_data    producer payload
//   out_valid  output-side stage holds a word
//   out_ready  consumer takes out_data this cycle
//   out_data   payload of the output-side stage
//   count      number of valid stages, from registered state only
// -----------------------------------------------------------------------------
module cv32e40x_elastic_pipe #(
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    DEPTH       = 2,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  count
);

  logic [WORD_WIDTH-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0]      valid_reg;

  // ready[k]: stage k may load this edge.
  logic [DEPTH-1:0]      ready;
  // What stage k would load: the producer for stage 0, the previous stage otherwise.
  logic [DEPTH-1:0]      load_valid;
  logic [WORD_WIDTH-1:0] load_data [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Unrolled form of ready[k] = !valid[k] | ready[k+1]: a stage can move
      // when the consumer takes a word or any stage from here to the output
      // end is empty. Written flat so the chain has no self-referencing vector.
      assign ready[gi] = out_ready | ~(&valid_reg[DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        assign load_valid[gi] = in_valid;
        assign load_data[gi]  = in_data;
      end else begin : g_body
        assign load_valid[gi] = valid_reg[gi-1];
        assign load_data[gi]  = data_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_reg[k] <= RESET_VALUE;
      end
    end else if (flush) begin
      // Data registers are left untouched on flush; only occupancy is dropped.
      valid_reg <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ready[k]) begin
          valid_reg[k] <= load_valid[k];
          // Only real words are written into the data registers.
          if (load_valid[k]) begin
            data_reg[k] <= load_data[k];
          end
        end
      end
    end
  end

  // Flush masks both handshakes so nothing transfers in the flushing cycle.
  assign in_ready  = ready[0] & ~flush;
  assign out_valid = valid_reg[DEPTH-1] & ~flush;
  assign out_data  = data_reg[DEPTH-1];

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CNT_WIDTH'(valid_reg[k]);
    end
  end

endmodule

// File: tb/tb_cv32e40x_elastic_pipe.sv
// -----------------------------------------------------------------------------
// Bench for cv32e40x_elastic_pipe. Four instances (DEPTH 1..4) share one input
// stimulus stream; each has its own reference model: an ordered list of words
// with their stage positions, moved by counting free slots ahead of each word.
// -----------------------------------------------------------------------------
module tb_cv32e40x_elastic_pipe;

  localparam int          W  = 32;
  localparam int          NI = 4;
  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic [NI-1:0]        in_ready, out_valid;
  logic [NI-1:0][W-1:0] out_data;
  logic [NI-1:0][2:0]   cnt;

  int checks   = 0;
  int failures = 0;

  // Model state per instance: n words, oldest first, with data and stage index.
  int          n        [NI];
  logic [31:0] wd       [NI][NI];
  int          wp       [NI][NI];
  logic [31:0] last_out [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = $clog2(gi + 2);
    logic [CW-1:0] cnt_w;
    cv32e40x_elastic_pipe #(
      .WORD_WIDTH (W),
      .DEPTH      (gi + 1),
      .RESET_VALUE(RV)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready[gi]),
      .in_data  (in_data),
      .out_valid(out_valid[gi]),
      .out_ready(out_ready),
      .out_data (out_data[gi]),
      .count    (cnt_w)
    );
    assign cnt[gi] = 3'(cnt_w);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      n[i]        = 0;
      last_out[i] = RV;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      int  d;
      bit  exp_ir, exp_ov;
      d      = i + 1;
      exp_ir = !flush && (out_ready || n[i] < d);
      exp_ov = !flush && n[i] > 0 && wp[i][0] == d - 1;
      check_val($sformatf("d%0d_in_ready", d),  32'(in_ready[i]),  32'(exp_ir));
      check_val($sformatf("d%0d_out_valid", d), 32'(out_valid[i]), 32'(exp_ov));
      check_val($sformatf("d%0d_out_data", d),  out_data[i],       last_out[i]);
      check_val($sformatf("d%0d_count", d),     32'(cnt[i]),       32'(n[i]));
    end
  endtask

  // Advance every model by one clock edge using the inputs currently driven.
  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      int d;
      bit acc, dep;
      d = i + 1;
      if (flush) begin
        n[i] = 0;
      end else begin
        acc = in_valid && (out_ready || n[i] < d);
        dep = out_ready && n[i] > 0 && wp[i][0] == d - 1;
        // Word j has j words ahead of it; it moves if the consumer is taking
        // or there are more slots ahead of it than words.
        for (int j = 0; j < n[i]; j++) begin
          if (wp[i][j] < d - 1 && (out_ready || (d - 1 - wp[i][j]) > j)) begin
            wp[i][j]++;
            if (wp[i][j] == d - 1) last_out[i] = wd[i][j];
          end
        end
        if (dep) begin
          for (int j = 0; j < n[i] - 1; j++) begin
            wd[i][j] = wd[i][j+1];
            wp[i][j] = wp[i][j+1];
          end
          n[i]--;
        end
        if (acc) begin
          wd[i][n[i]] = in_data;
          wp[i][n[i]] = 0;
          n[i]++;
          if (d == 1) last_out[i] = in_data;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] dat, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] words [3];
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    #1 check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    $display("phase stream: 11,22,33 with out_ready=1");
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int k = 0; k < 3; k++) begin drive(1'b1, words[k], 1'b1, 1'b0); step(); end
    drive(1'b0, '0, 1'b1, 1'b0); repeat (5) step();

    $display("phase backpressure: A,B,C with out_ready=0 then release");
    words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC;
    for (int k = 0; k < 3; k++) begin drive(1'b1, words[k], 1'b0, 1'b0); step(); end
    drive(1'b1, 32'hC, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b1, 1'b0); repeat (6) step();

    $display("phase bubble: one word, stall, second word, drain");
    drive(1'b1, 32'h5A5A_0001, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0); repeat (4) step();
    drive(1'b1, 32'h5A5A_0002, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0); repeat (3) step();
    drive(1'b0, '0, 1'b1, 1'b0); repeat (5) step();

    $display("phase flush: three words then flush with in_valid and out_ready");
    for (int k = 0; k < 3; k++) begin drive(1'b1, 32'hF000 + 32'(k), 1'b0, 1'b0); step(); end
    drive(1'b1, 32'hF0F0_F0F0, 1'b1, 1'b1); step();
    drive(1'b0, '0, 1'b0, 1'b0); repeat (2) step();

    $display("phase passthrough: fill then 10 cycles in and out");
    for (int k = 0; k < 4; k++) begin drive(1'b1, 32'h7000 + 32'(k), 1'b0, 1'b0); step(); end
    for (int k = 0; k < 10; k++) begin drive(1'b1, 32'h8000 + 32'(k), 1'b1, 1'b0); step(); end
    drive(1'b0, '0, 1'b1, 1'b0); repeat (5) step();

    $display("phase random: 3000 cycles");
    for (int k = 0; k < 3000; k++) begin
      int mode;
      mode = (k / 250) % 4;
      drive($urandom_range(99) < (mode == 1 ? 90 : 60), $urandom(),
            $urandom_range(99) < (mode == 2 ? 20 : (mode == 3 ? 95 : 55)),
            $urandom_range(99) < 3);
      step();
    end

    $display("phase reset: fill, then assert rst between edges");
    for (int k = 0; k < 5; k++) begin drive(1'b1, 32'h9000 + 32'(k), 1'b0, 1'b0); step(); end
    rst = 1'b1;
    model_reset();
    #1 check_outputs();
    @(negedge clk); check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      drive($urandom_range(1) == 1, $urandom(), $urandom_range(1) == 1, 1'b0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
